// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcode enum, MEM-stage controller states, byte-enable codes
// and opcode classification helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB = 4'h3,
    OP_JSR  = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
    OP_RTI  = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
    OP_JMP  = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
  } lc3b_opcode;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } mem_ctrl_state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  function automatic logic is_load(lc3b_opcode op);
    return op inside {OP_LDB, OP_LDR, OP_LDI};
  endfunction

  function automatic logic is_store(lc3b_opcode op);
    return op inside {OP_STB, OP_STR, OP_STI};
  endfunction

  function automatic logic is_indirect(lc3b_opcode op);
    return op inside {OP_LDI, OP_STI};
  endfunction

  function automatic logic is_byte_op(lc3b_opcode op);
    return op inside {OP_LDB, OP_STB};
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_lane_steer.sv
// Byte-lane steering for the MEM stage: byte enables, store-data replication
// and load byte selection with zero extension.
module mem_lane_steer
  import lc3b_types::*;
(
  input  logic        byte_op,
  input  logic        lane_hi,
  input  logic [15:0] st_data,
  input  logic [15:0] rdata,
  output logic [1:0]  byte_en,
  output logic [15:0] wdata,
  output logic [15:0] load_val
);

  always_comb begin
    byte_en  = BE_WORD;
    wdata    = st_data;
    load_val = rdata;
    if (byte_op) begin
      // The store byte goes on both lanes; the enable picks which one lands.
      byte_en  = lane_hi ? BE_HI : BE_LO;
      wdata    = {st_data[7:0], st_data[7:0]};
      load_val = lane_hi ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage sequencer for LDB/LDR/LDI/STB/STR/STI with watchdog.
// Optional macro MEM_STAGE_CTRL_ALIGN_CHECK_EN aborts misaligned word accesses.
module mem_stage_ctrl
  import lc3b_types::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  opcode,
  input  logic [15:0] eff_addr,
  input  logic [15:0] st_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_en,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic [15:0] load_data,
  output logic        done,
  output logic        err,
  output logic        misalign,
  output logic [1:0]  dbg_state
);

`ifdef MEM_STAGE_CTRL_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one request is in flight.
  mem_ctrl_state_t state_q;
  lc3b_opcode      op_q, op_in;
  logic [15:0]     addr_q, data_q, ptr_q, load_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q, mis_q, timeout_hit;
  logic [1:0]      steer_be;
  logic [15:0]     steer_wdata, steer_load;

  assign op_in       = lc3b_opcode'(opcode);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  mem_lane_steer u_steer (
    .byte_op  (is_byte_op(op_q)),
    .lane_hi  (addr_q[0]),
    .st_data  (data_q),
    .rdata    (mem_rdata),
    .byte_en  (steer_be),
    .wdata    (steer_wdata),
    .load_val (steer_load)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_BR;
      addr_q  <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
      load_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          op_q   <= op_in;
          addr_q <= eff_addr;
          data_q <= st_data;
          cnt_q  <= '0;
          if (!(is_load(op_in) || is_store(op_in))) begin
            state_q <= DONE;
          end else if (ALIGN_CHECK && !is_byte_op(op_in) && eff_addr[0]) begin
            state_q <= DONE;
            mis_q   <= 1'b1;
          end else begin
            state_q <= is_indirect(op_in) ? PTR : DATA;
          end
        end
        PTR: if (mem_resp) begin
          ptr_q <= mem_rdata;
          cnt_q <= '0;
          if (ALIGN_CHECK && mem_rdata[0]) begin
            state_q <= DONE;
            mis_q   <= 1'b1;
          end else begin
            state_q <= DATA;
          end
        end else if (timeout_hit) begin
          state_q <= DONE;
          err_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        DATA: if (mem_resp) begin
          state_q <= DONE;
          load_q  <= is_load(op_q) ? steer_load : '0;
        end else if (timeout_hit) begin
          state_q <= DONE;
          err_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        default: begin
          state_q <= IDLE;
          load_q  <= '0;
          err_q   <= 1'b0;
          mis_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_byte_en = '0;
    mem_wdata   = '0;
    if (state_q == PTR) begin
      mem_read    = 1'b1;
      mem_address = {addr_q[15:1], 1'b0};
      mem_byte_en = BE_WORD;
    end else if (state_q == DATA) begin
      mem_read    = is_load(op_q);
      mem_write   = is_store(op_q);
      mem_byte_en = steer_be;
      mem_wdata   = is_store(op_q) ? steer_wdata : '0;
      if (is_indirect(op_q))     mem_address = {ptr_q[15:1], 1'b0};
      else if (is_byte_op(op_q)) mem_address = addr_q;
      else                       mem_address = {addr_q[15:1], 1'b0};
    end
  end

  assign req_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign load_data = load_q;
  assign err       = err_q;
  assign misalign  = mis_q & ALIGN_CHECK;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: a randomly delayed memory responder plus a
// transaction-level model of expected accesses, load results and latency.
module tb_mem_stage_ctrl;
  import lc3b_types::*;

`ifdef MEM_STAGE_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0;
  logic [3:0]  opcode = '0;
  logic [15:0] eff_addr = '0, st_data = '0;
  logic        mem_read, mem_write, req_ready, done, err, misalign;
  logic [15:0] mem_address, mem_wdata, load_data;
  logic [1:0]  mem_byte_en, dbg_state;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;

  mem_stage_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .eff_addr(eff_addr), .st_data(st_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .load_data(load_data), .done(done), .err(err),
    .misalign(misalign), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  // scoreboard: access = {write, address, byte_en, wdata(writes only)}
  logic [34:0] exp_q[$];
  logic [34:0] obs_q[$];
  int          dly_q[$];
  logic [15:0] mem [int];
  bit          mute = 1'b0;
  int          fixed_dly = -1, cur_dly = 0, wait_cnt = 0;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int w);
    if (!mem.exists(w)) mem[w] = 16'($urandom);
    return mem[w];
  endfunction

  // memory responder: answers the current strobe after cur_dly cycles
  always @(negedge clk) begin
    logic [15:0] t;
    mem_resp  = 1'b0;
    mem_rdata = 16'($urandom);
    if (rst_n && !mute && (mem_read || mem_write)) begin
      if (wait_cnt >= cur_dly) begin
        t = mem_rd(int'(mem_address[15:1]));
        mem_resp = 1'b1;
        if (mem_read) mem_rdata = t;
        if (mem_write) begin
          if (mem_byte_en[0]) t[7:0]  = mem_wdata[7:0];
          if (mem_byte_en[1]) t[15:8] = mem_wdata[15:8];
          mem[int'(mem_address[15:1])] = t;
        end
        obs_q.push_back({mem_write, mem_address, mem_byte_en, mem_write ? mem_wdata : 16'h0});
        dly_q.push_back(cur_dly);
        cur_dly  = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // reference model: expected accesses, load value and misalign flag
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] sd,
                       output logic [15:0] ld, output logic mis);
    logic [15:0] w, p;
    ld = '0; mis = 1'b0;
    w  = {a[15:1], 1'b0};
    case (lc3b_opcode'(op))
      OP_LDB: begin
        exp_q.push_back({1'b0, a, a[0] ? 2'b10 : 2'b01, 16'h0});
        p  = mem_rd(int'(a[15:1]));
        ld = a[0] ? {8'h0, p[15:8]} : {8'h0, p[7:0]};
      end
      OP_STB: exp_q.push_back({1'b1, a, a[0] ? 2'b10 : 2'b01, sd[7:0], sd[7:0]});
      OP_LDR: if (ALIGN && a[0]) mis = 1'b1;
              else begin
                exp_q.push_back({1'b0, w, 2'b11, 16'h0});
                ld = mem_rd(int'(a[15:1]));
              end
      OP_STR: if (ALIGN && a[0]) mis = 1'b1;
              else exp_q.push_back({1'b1, w, 2'b11, sd});
      OP_LDI, OP_STI: if (ALIGN && a[0]) mis = 1'b1;
              else begin
                exp_q.push_back({1'b0, w, 2'b11, 16'h0});
                p = mem_rd(int'(a[15:1]));
                if (ALIGN && p[0]) mis = 1'b1;
                else if (lc3b_opcode'(op) == OP_LDI) begin
                  exp_q.push_back({1'b0, p[15:1], 1'b0, 2'b11, 16'h0});
                  ld = mem_rd(int'(p[15:1]));
                end else begin
                  exp_q.push_back({1'b1, p[15:1], 1'b0, 2'b11, sd});
                end
              end
      default: ;
    endcase
  endtask

  // driver: one request, then check the whole transaction
  task automatic do_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] sd,
                        input string tag, output logic [15:0] got_ld);
    logic [15:0] e_ld;
    logic        e_mis;
    int          acc, sum, n_acc;
    bit          seen, busy_bad;
    exp_q.delete(); obs_q.delete(); dly_q.delete();
    model(op, a, sd, e_ld, e_mis);
    n_acc = exp_q.size();
    got_ld = 'x;
    @(negedge clk);
    check({tag, "_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; opcode = op; eff_addr = a; st_data = sd; acc = cyc;
    @(negedge clk);
    req_valid = 1'b0; opcode = 4'($urandom); eff_addr = 16'($urandom); st_data = 16'($urandom);
    seen = 0; busy_bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (req_ready !== 1'b0) busy_bad = 1;
      if (done === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_ready_busy"}, busy_bad, 0);
    if (seen) begin
      sum = 0;
      foreach (dly_q[i]) sum += dly_q[i];
      got_ld = load_data;
      check({tag, "_latency"}, cyc - acc, 1 + n_acc + sum);
      check({tag, "_load"}, load_data, e_ld);
      check({tag, "_err"}, err, 0);
      check({tag, "_misalign"}, misalign, e_mis);
      check({tag, "_n_access"}, obs_q.size(), n_acc);
      for (int i = 0; i < n_acc && i < obs_q.size(); i++)
        check({tag, "_access"}, obs_q[i], exp_q[i]);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
    end
  endtask

  initial begin
    logic [15:0] ld;
    int          acc;
    bit          seen;
    logic [3:0]  ops[8] = '{4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB, 4'h1, 4'hE};

    for (int i = 0; i < 64; i++) mem[16'h4000 + i] = 16'h8000 | 16'($urandom_range(0, 127));
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_strobes", {mem_read, mem_write, mem_byte_en}, 0);
    check("rst_addr_wdata", {mem_address, mem_wdata}, 0);
    check("rst_outs", {load_data, done, err, misalign}, 0);
    rst_n = 1'b1;

    fixed_dly = 2; cur_dly = 2;
    mem[16'h3002 >> 1] = 16'h1234;
    do_req(4'h6, 16'h3002, 16'h0, "ldr", ld);
    check("ldr_value", ld, 16'h1234);
    if (obs_q.size() > 0) check("ldr_access", obs_q[0], {1'b0, 16'h3002, 2'b11, 16'h0});

    fixed_dly = 0; cur_dly = 0;
    mem[16'h3000 >> 1] = 16'hABCD;
    do_req(4'h2, 16'h3001, 16'h0, "ldb_hi", ld);
    check("ldb_hi_value", ld, 16'h00AB);
    do_req(4'h2, 16'h3000, 16'h0, "ldb_lo", ld);
    check("ldb_lo_value", ld, 16'h00CD);
    do_req(4'h3, 16'h4001, 16'h0012, "stb", ld);
    if (obs_q.size() > 0) check("stb_access", obs_q[0], {1'b1, 16'h4001, 2'b10, 16'h1212});

    fixed_dly = 1; cur_dly = 1;
    mem[16'h5000 >> 1] = 16'h6000; mem[16'h6000 >> 1] = 16'hBEEF;
    do_req(4'hA, 16'h5000, 16'h0, "ldi", ld);
    check("ldi_value", ld, 16'hBEEF);
    do_req(4'hB, 16'h5000, 16'h5A5A, "sti", ld);
    if (obs_q.size() > 1) check("sti_write", obs_q[1], {1'b1, 16'h6000, 2'b11, 16'h5A5A});

    do_req(4'h7, 16'h7001, 16'hC0DE, "str_odd", ld);
`ifdef MEM_STAGE_CTRL_ALIGN_CHECK_EN
    check("str_odd_no_access", obs_q.size(), 0);
`else
    if (obs_q.size() > 0) check("str_odd_forced", obs_q[0], {1'b1, 16'h7000, 2'b11, 16'hC0DE});
`endif
    do_req(4'h1, 16'h1234, 16'h0, "nonmem", ld);

    // watchdog: direct and indirect accesses with a silent memory
    mute = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 1'b1; opcode = (k == 0) ? 4'h6 : 4'hA; eff_addr = 16'h3000; acc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      check("wd_strobe", {mem_read, mem_address}, {1'b1, 16'h3000});
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        if (done === 1'b1) begin seen = 1; break; end
        @(negedge clk);
      end
      check("wd_done_seen", seen, 1);
      check("wd_latency", cyc - acc, 9);
      check("wd_err_load", {err, load_data}, {1'b1, 16'h0});
      @(negedge clk);
    end

    // reset during the pointer phase of an LDI
    @(negedge clk);
    req_valid = 1'b1; opcode = 4'hA; eff_addr = 16'h5000;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_ptr_read", mem_read, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_strobes", {mem_read, mem_write, done}, 0);
    check("rstmid_ready", req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_no_done", done, 0);
    mute = 1'b0;

    // randomized transactions
    fixed_dly = -1; cur_dly = 0;
    for (int n = 0; n < 60; n++)
      do_req(ops[$urandom_range(0, 7)], 16'h8000 | 16'($urandom_range(0, 127)),
             16'($urandom), "rand", ld);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
